dmem_arbiter: RTL and testbench

Two-requester arbiter sharing the single data-memory/IO port behind the LSU between the core's load/store path and a debug/DMA master. It serialises accesses with a round-robin 3-state FSM, returns read data with a one-cycle ack pulse, and produces a stall for the core while its access is outstanding. It sits between the core datapath (ALU address, rs2 store data, `ld_data` writeback) and the memory/IO block.

---
 rtl/dmem_arb_pkg.sv | 23 ++
 rtl/sat_counter.sv | 19 +
 rtl/dmem_arbiter.sv | 145 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and reset constants for the data-memory port arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_e;

  typedef enum logic {
    PORT_CORE = 1'b0,
    PORT_DBG  = 1'b1
  } arb_port_e;

  localparam arb_port_e GRANT_RST      = PORT_CORE;
  // Debug counts as last served so the core wins the first conflict.
  localparam arb_port_e LAST_GRANT_RST = PORT_DBG;

  function automatic arb_port_e other_port(input arb_port_e p);
    return (p == PORT_CORE) ? PORT_DBG : PORT_CORE;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_cnt <= '0;
    end else if (i_inc && (o_cnt != {CNT_W{1'b1}})) begin
      o_cnt <= o_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the single data-memory/IO port between the core
// load/store path and a debug/DMA master; one access in flight at a time.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_c_req,
  input  logic              i_c_we,
  input  logic [ADDR_W-1:0] i_c_addr,
  input  logic [DATA_W-1:0] i_c_wdata,
  output logic [DATA_W-1:0] o_c_rdata,
  output logic              o_c_ack,
  output logic              o_c_stall,
  input  logic              i_d_req,
  input  logic              i_d_we,
  input  logic [ADDR_W-1:0] i_d_addr,
  input  logic [DATA_W-1:0] i_d_wdata,
  output logic [DATA_W-1:0] o_d_rdata,
  output logic              o_d_ack,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic              o_mem_wren,
  output logic              o_mem_rden,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic [CNT_W-1:0]  o_stall_cnt
);

  arb_state_e        state_q, state_d;
  arb_port_e         grant_q, grant_d;
  arb_port_e         last_grant_q, last_grant_d;
  arb_port_e         pick;
  logic              start;
  logic              pick_we;
  logic              rd_q, rd_d;
  logic              c_ack_d, d_ack_d;
  logic              wren_d, rden_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_d;

  // State, grant bookkeeping and all registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      grant_q      <= GRANT_RST;
      last_grant_q <= LAST_GRANT_RST;
      rd_q         <= 1'b0;
      o_c_ack      <= 1'b0;
      o_d_ack      <= 1'b0;
      o_mem_wren   <= 1'b0;
      o_mem_rden   <= 1'b0;
      o_mem_addr   <= '0;
      o_mem_wdata  <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      rd_q         <= rd_d;
      o_c_ack      <= c_ack_d;
      o_d_ack      <= d_ack_d;
      o_mem_wren   <= wren_d;
      o_mem_rden   <= rden_d;
      o_mem_addr   <= addr_d;
      o_mem_wdata  <= wdata_d;
    end
  end

  // Next-state, arbitration and memory-side mux.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    rd_d         = rd_q;
    c_ack_d      = 1'b0;
    d_ack_d      = 1'b0;
    wren_d       = 1'b0;
    rden_d       = 1'b0;
    addr_d       = o_mem_addr;
    wdata_d      = o_mem_wdata;
    start        = 1'b0;
    pick         = grant_q;
    pick_we      = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_c_req && i_d_req) begin
          start = 1'b1;
          pick  = other_port(last_grant_q);
        end else if (i_c_req) begin
          start = 1'b1;
          pick  = PORT_CORE;
        end else if (i_d_req) begin
          start = 1'b1;
          pick  = PORT_DBG;
        end
      end
      ACCESS: begin
        state_d      = RESP;
        last_grant_d = grant_q;
        c_ack_d      = (grant_q == PORT_CORE);
        d_ack_d      = (grant_q == PORT_DBG);
      end
      RESP: begin
        // The port being acked now is ignored; only the other one may chain.
        pick    = other_port(grant_q);
        start   = (grant_q == PORT_CORE) ? i_d_req : i_c_req;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (start) begin
      state_d = ACCESS;
      grant_d = pick;
      if (pick == PORT_CORE) begin
        addr_d  = i_c_addr;
        wdata_d = i_c_wdata;
        pick_we = i_c_we;
      end else begin
        addr_d  = i_d_addr;
        wdata_d = i_d_wdata;
        pick_we = i_d_we;
      end
      wren_d = pick_we;
      rden_d = !pick_we;
      rd_d   = !pick_we;
    end
  end

  assign o_c_rdata = (o_c_ack && rd_q) ? i_mem_rdata : '0;
  assign o_d_rdata = (o_d_ack && rd_q) ? i_mem_rdata : '0;
  assign o_c_stall = i_c_req & ~o_c_ack;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_inc   (o_c_stall),
    .o_cnt   (o_stall_cnt)
  );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: vector table, directed corner cases,
// and random traffic against a transaction-schedule reference model.
`timescale 1ns/1ps
module tb_dmem_arbiter;

  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned CW  = 4;
  localparam int unsigned SAT = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          c_req = 1'b0, c_we = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [AW-1:0] c_addr = '0, d_addr = '0;
  logic [DW-1:0] c_wdata = '0, d_wdata = '0;
  logic [DW-1:0] c_rdata, d_rdata, mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic [AW-1:0] mem_addr;
  logic          c_ack, d_ack, c_stall, mem_wren, mem_rden;
  logic [CW-1:0] stall_cnt;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_c_req(c_req), .i_c_we(c_we), .i_c_addr(c_addr), .i_c_wdata(c_wdata),
    .o_c_rdata(c_rdata), .o_c_ack(c_ack), .o_c_stall(c_stall),
    .i_d_req(d_req), .i_d_we(d_we), .i_d_addr(d_addr), .i_d_wdata(d_wdata),
    .o_d_rdata(d_rdata), .o_d_ack(d_ack),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_wren(mem_wren),
    .o_mem_rden(mem_rden), .i_mem_rdata(mem_rdata), .o_stall_cnt(stall_cnt)
  );

  // Test memory: 256 words, unwritten words read a fixed address pattern.
  function automatic logic [31:0] dflt(input logic [31:0] a);
    return (a == 32'h10) ? 32'hDEAD_BEEF : (a ^ 32'hC0DE_0000);
  endfunction
  function automatic int unsigned idx(input logic [31:0] a);
    return {24'd0, a[9:2]};
  endfunction

  logic [31:0]  tmem [0:255];
  logic [255:0] tval;
  bit           mem_clr = 1'b1;
  always @(posedge clk) begin
    if (mem_clr) tval <= '0;
    else if (mem_wren) begin
      tmem[idx(mem_addr)] <= mem_wdata;
      tval[idx(mem_addr)] <= 1'b1;
    end
    if (mem_rden) mem_rdata <= tval[idx(mem_addr)] ? tmem[idx(mem_addr)] : dflt(mem_addr);
  end

  // Reference model: each grant is an access record scheduled on the cycle
  // timeline (strobe at decision+1, ack at decision+2, next decision at ack).
  typedef struct {
    int          acc;
    logic        port;
    logic        we;
    logic [31:0] addr, wdata, rdata;
  } acc_t;

  acc_t        q[$];
  int          cyc, free_at;
  logic        last;
  int unsigned mcnt;
  logic [31:0] mmem [0:255];
  logic        c_seen, d_seen;
  int          checks = 0, errors = 0;
  int          c_mode = 0, d_mode = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    cyc = 0; free_at = 0; last = 1'b1; mcnt = 0;
    c_seen = 1'b0; d_seen = 1'b0;
  endtask

  // Called at the negedge of every cycle: compare, then arbitrate for the next edge.
  task automatic model_check();
    logic e_rd = 0, e_wr = 0, e_ca = 0, e_da = 0, ack_v = 0, ack_p = 0, e_st;
    logic cr, dr, win;
    logic [31:0] e_a = 0, e_w = 0, e_cr = 0, e_dr = 0;
    acc_t r;
    foreach (q[i]) begin
      if (q[i].acc == cyc) begin
        e_rd = !q[i].we; e_wr = q[i].we; e_a = q[i].addr; e_w = q[i].wdata;
      end
      if (q[i].acc + 1 == cyc) begin
        ack_v = 1'b1; ack_p = q[i].port;
        if (q[i].port) begin e_da = 1'b1; e_dr = q[i].rdata; end
        else           begin e_ca = 1'b1; e_cr = q[i].rdata; end
      end
    end
    e_st = c_req & ~e_ca;
    chk("rden", 32'(mem_rden), 32'(e_rd));
    chk("wren", 32'(mem_wren), 32'(e_wr));
    if (e_rd || e_wr) chk("mem_addr", mem_addr, e_a);
    if (e_wr) chk("mem_wdata", mem_wdata, e_w);
    chk("c_ack", 32'(c_ack), 32'(e_ca));
    chk("d_ack", 32'(d_ack), 32'(e_da));
    chk("c_rdata", c_rdata, e_cr);
    chk("d_rdata", d_rdata, e_dr);
    chk("c_stall", 32'(c_stall), 32'(e_st));
    chk("stall_cnt", 32'(stall_cnt), mcnt);
    c_seen = c_ack; d_seen = d_ack;
    if (cyc >= free_at) begin
      cr = c_req && !(ack_v && !ack_p);
      dr = d_req && !(ack_v && ack_p);
      if (cr || dr) begin
        win = (cr && dr) ? ~last : !cr;
        r.acc   = cyc + 1;
        r.port  = win;
        r.we    = win ? d_we : c_we;
        r.addr  = win ? d_addr : c_addr;
        r.wdata = win ? d_wdata : c_wdata;
        if (r.we) begin mmem[idx(r.addr)] = r.wdata; r.rdata = '0; end
        else r.rdata = mmem[idx(r.addr)];
        q.push_back(r);
        last = win;
        free_at = cyc + 2;
      end
    end
    if (e_st && mcnt < SAT) mcnt++;
    while (q.size() > 0 && q[0].acc + 1 <= cyc) q.delete(0);
    cyc++;
  endtask

  task automatic step();
    @(negedge clk);
    model_check();
    @(posedge clk);
    #1;
  endtask

  // Requesters: hold each transfer through its ack, then optionally start another.
  task automatic drive();
    if (c_req && c_seen) c_req = 1'b0;
    if (!c_req && (c_mode == 2 || (c_mode == 1 && $urandom_range(0, 1) == 1))) begin
      c_req = 1'b1; c_we = 1'($urandom_range(0, 1));
      c_addr = 32'($urandom_range(0, 15) * 4); c_wdata = $urandom;
    end
    if (d_req && d_seen) d_req = 1'b0;
    if (!d_req && (d_mode == 2 || (d_mode == 1 && $urandom_range(0, 1) == 1))) begin
      d_req = 1'b1; d_we = 1'($urandom_range(0, 1));
      d_addr = 32'($urandom_range(0, 15) * 4); d_wdata = $urandom;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
  endtask

  typedef struct {
    bit          rst;
    logic        c_req, c_we;
    logic [31:0] c_addr, c_wdata;
    logic        d_req, d_we;
    logic [31:0] d_addr, d_wdata;
    logic        rden, wren;
    logic [31:0] maddr;
    logic        cack, dack;
    logic [31:0] crd, drd;
    logic        stall;
    logic [3:0]  cnt;
  } vec_t;

  vec_t tv [10];

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int c_n, d_n, ovl, lat;
    bit got;
    int acks[$];

    // Core read alone, then simultaneous core write / debug read of one word.
    tv[0] = '{1, 1,0,32'h10,32'h0,        0,0,32'h0,32'h0,  0,0,32'h0,  0,0,32'h0,32'h0,         1,4'd0};
    tv[1] = '{0, 1,0,32'h10,32'h0,        0,0,32'h0,32'h0,  1,0,32'h10, 0,0,32'h0,32'h0,         1,4'd1};
    tv[2] = '{0, 1,0,32'h10,32'h0,        0,0,32'h0,32'h0,  0,0,32'h0,  1,0,32'hDEAD_BEEF,32'h0, 0,4'd2};
    tv[3] = '{0, 0,0,32'h0,32'h0,         0,0,32'h0,32'h0,  0,0,32'h0,  0,0,32'h0,32'h0,         0,4'd2};
    tv[4] = '{1, 1,1,32'h20,32'h1234_5678, 1,0,32'h20,32'h0, 0,0,32'h0,  0,0,32'h0,32'h0,         1,4'd0};
    tv[5] = '{0, 1,1,32'h20,32'h1234_5678, 1,0,32'h20,32'h0, 0,1,32'h20, 0,0,32'h0,32'h0,         1,4'd1};
    tv[6] = '{0, 1,1,32'h20,32'h1234_5678, 1,0,32'h20,32'h0, 0,0,32'h0,  1,0,32'h0,32'h0,         0,4'd2};
    tv[7] = '{0, 0,0,32'h0,32'h0,         1,0,32'h20,32'h0, 1,0,32'h20, 0,0,32'h0,32'h0,         0,4'd2};
    tv[8] = '{0, 0,0,32'h0,32'h0,         1,0,32'h20,32'h0, 0,0,32'h0,  0,1,32'h0,32'h1234_5678, 0,4'd2};
    tv[9] = '{0, 0,0,32'h0,32'h0,         0,0,32'h0,32'h0,  0,0,32'h0,  0,0,32'h0,32'h0,         0,4'd2};

    for (int i = 0; i < 256; i++) mmem[i] = dflt(32'(i * 4));
    model_reset();
    do_reset();
    mem_clr = 1'b0;

    chk("rst_c_ack", 32'(c_ack), 0);
    chk("rst_d_ack", 32'(d_ack), 0);
    chk("rst_rden", 32'(mem_rden), 0);
    chk("rst_wren", 32'(mem_wren), 0);
    chk("rst_c_rdata", c_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_cnt", 32'(stall_cnt), 0);

    for (int i = 0; i < 10; i++) begin
      if (tv[i].rst) do_reset();
      c_req = tv[i].c_req; c_we = tv[i].c_we; c_addr = tv[i].c_addr; c_wdata = tv[i].c_wdata;
      d_req = tv[i].d_req; d_we = tv[i].d_we; d_addr = tv[i].d_addr; d_wdata = tv[i].d_wdata;
      @(negedge clk);
      chk($sformatf("tv%0d_rden", i), 32'(mem_rden), 32'(tv[i].rden));
      chk($sformatf("tv%0d_wren", i), 32'(mem_wren), 32'(tv[i].wren));
      if (tv[i].rden || tv[i].wren) chk($sformatf("tv%0d_addr", i), mem_addr, tv[i].maddr);
      chk($sformatf("tv%0d_cack", i), 32'(c_ack), 32'(tv[i].cack));
      chk($sformatf("tv%0d_dack", i), 32'(d_ack), 32'(tv[i].dack));
      chk($sformatf("tv%0d_crd", i), c_rdata, tv[i].crd);
      chk($sformatf("tv%0d_drd", i), d_rdata, tv[i].drd);
      chk($sformatf("tv%0d_stall", i), 32'(c_stall), 32'(tv[i].stall));
      chk($sformatf("tv%0d_cnt", i), 32'(stall_cnt), 32'(tv[i].cnt));
      model_check();
      @(posedge clk);
      #1;
    end

    // Reset asserted in the middle of a core write's ACCESS cycle.
    do_reset();
    c_req = 1'b1; c_we = 1'b1; c_addr = 32'h3F0; c_wdata = 32'hA5A5_5A5A;
    step();
    chk("rstacc_wren_pre", 32'(mem_wren), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstacc_wren", 32'(mem_wren), 0);
    chk("rstacc_rden", 32'(mem_rden), 0);
    c_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      step();
      chk("rstacc_no_ack", 32'(c_ack | d_ack), 0);
    end
    c_req = 1'b1; c_we = 1'b0; c_addr = 32'h10;
    lat = 99; got = 1'b0;
    for (int k = 0; k < 6 && !got; k++) begin
      @(negedge clk);
      if (c_ack) begin
        got = 1'b1; lat = k;
        chk("rstacc_rdata", c_rdata, 32'hDEAD_BEEF);
      end
      model_check();
      @(posedge clk);
      #1;
    end
    chk("rstacc_latency", 32'(lat), 2);
    c_req = 1'b0;
    step();

    // Lone debug master issuing back-to-back reads.
    do_reset();
    c_mode = 0; d_mode = 2;
    acks.delete();
    for (int k = 0; k < 9; k++) begin
      drive();
      d_we = 1'b0;
      @(negedge clk);
      if (d_ack) acks.push_back(k);
      chk("lone_core_quiet", {c_rdata[30:0] | c_rdata[31], 1'b0} | 32'(c_ack) | 32'(c_stall), 0);
      model_check();
      @(posedge clk);
      #1;
    end
    chk("lone_ack_count", 32'(acks.size()), 3);
    if (acks.size() == 3) begin
      chk("lone_first_ack", 32'(acks[0]), 2);
      chk("lone_gap1", 32'(acks[1] - acks[0]), 3);
      chk("lone_gap2", 32'(acks[2] - acks[1]), 3);
    end

    // Both ports saturating the arbiter; also drives the stall counter to its ceiling.
    do_reset();
    c_mode = 2; d_mode = 2;
    c_n = 0; d_n = 0; ovl = 0;
    for (int k = 0; k < 21; k++) begin
      drive();
      @(negedge clk);
      if (c_ack) c_n++;
      if (d_ack) d_n++;
      if ((c_ack && d_ack) || (mem_rden && mem_wren)) ovl++;
      model_check();
      @(posedge clk);
      #1;
    end
    chk("cont_core_acks", 32'(c_n), 5);
    chk("cont_dbg_acks", 32'(d_n), 5);
    chk("cont_overlap", 32'(ovl), 0);
    chk("cont_sat", 32'(stall_cnt), SAT);
    for (int k = 0; k < 5; k++) begin
      drive();
      step();
      chk("cont_sat_hold", 32'(stall_cnt), SAT);
    end

    // Random traffic from both ports.
    do_reset();
    c_mode = 1; d_mode = 1;
    for (int k = 0; k < 400; k++) begin
      drive();
      step();
    end
    c_mode = 0; d_mode = 0;
    for (int k = 0; k < 8; k++) begin
      drive();
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
